// File: rtl/icache_sa.sv
// Set-associative instruction cache with combinational hit path and a single-line refill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_sa #(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 64,
   parameter int unsigned LINE_WORDS = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cpu_addr_valid,
   input  logic [31:0]              cpu_addr,
   input  logic                     flush,
   output logic                     cpu_data_ready,
   output logic [31:0]              cpu_data_o,
   output logic                     mem_addr_valid,
   output logic [31:0]              mem_addr,
   input  logic                     mem_data_ready,
   input  logic [LINE_WORDS*32-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   localparam int unsigned WordW = $clog2(LINE_WORDS);
   localparam int unsigned OffW  = WordW + 2;
   localparam int unsigned IdxW  = $clog2(SETS);
   localparam int unsigned TagW  = 32 - OffW - IdxW;
   localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {StIdle, StRefill} state_e;

   state_e                  state_q, state_d;
   logic [TagW+IdxW-1:0]    line_q, line_d;
   logic [WayW-1:0]         victim_q, victim_d;
   logic                    discard_q, discard_d;
   logic [WAYS-1:0]         valid_q [SETS];
   logic [WayW-1:0]         rr_q [SETS];
   logic [TagW-1:0]         tag_q [SETS][WAYS];
   logic [LINE_WORDS*32-1:0] data_q [SETS][WAYS];

   logic [IdxW-1:0]         cpu_idx;
   logic [TagW-1:0]         cpu_tag;
   logic [WordW-1:0]        cpu_word;
   logic [IdxW-1:0]         fill_idx;
   logic [TagW-1:0]         fill_tag;
   logic                    hit, miss, fill, fill_keep;
   logic [WayW-1:0]         hit_way, victim;
   logic [LINE_WORDS*32-1:0] rd_line;
   logic                    unused_addr;

   assign cpu_idx     = cpu_addr[OffW +: IdxW];
   assign cpu_tag     = cpu_addr[31 -: TagW];
   assign cpu_word    = cpu_addr[2 +: WordW];
   assign fill_idx    = line_q[0 +: IdxW];
   assign fill_tag    = line_q[IdxW +: TagW];
   assign unused_addr = ^cpu_addr[1:0];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (valid_q[cpu_idx][w] && (tag_q[cpu_idx][w] == cpu_tag)) begin
            hit     = 1'b1;
            hit_way = WayW'(w);
         end
      end
   end

   assign rd_line        = data_q[cpu_idx][hit_way];
   assign cpu_data_o     = rd_line[{cpu_word, 5'b0} +: 32];
   assign cpu_data_ready = cpu_addr_valid & (state_q == StIdle) & ~flush & hit;
   assign miss           = cpu_addr_valid & (state_q == StIdle) & ~flush & ~hit;

   // Prefer the lowest invalid way; fall back to the set's round-robin pointer.
   always_comb begin
      logic found;
      found  = 1'b0;
      victim = rr_q[cpu_idx];
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!found && !valid_q[cpu_idx][w]) begin
            victim = WayW'(w);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      line_d         = line_q;
      victim_d       = victim_q;
      discard_d      = discard_q;
      fill           = 1'b0;
      mem_addr_valid = 1'b0;
      mem_addr       = '0;
      unique case (state_q)
         StIdle: begin
            if (miss) begin
               line_d    = cpu_addr[31:OffW];
               victim_d  = victim;
               discard_d = 1'b0;
               state_d   = StRefill;
            end
         end
         StRefill: begin
            mem_addr_valid = 1'b1;
            mem_addr       = {line_q, {OffW{1'b0}}};
            if (flush) begin
               discard_d = 1'b1;
            end
            if (mem_data_ready) begin
               fill    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A flush seen anywhere in the refill window leaves the returned line invalid.
   assign fill_keep = fill & ~discard_q & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         line_q    <= '0;
         victim_q  <= '0;
         discard_q <= 1'b0;
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         victim_q  <= victim_d;
         discard_q <= discard_d;
         if (flush) begin
            for (int s = 0; s < int'(SETS); s++) begin
               valid_q[s] <= '0;
            end
         end else if (fill_keep) begin
            valid_q[fill_idx][victim_q] <= 1'b1;
         end
         if (fill_keep) begin
            rr_q[fill_idx] <= (rr_q[fill_idx] == WayW'(WAYS - 1)) ? '0 : rr_q[fill_idx] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         data_q[fill_idx][victim_q] <= mem_data_i;
         tag_q[fill_idx][victim_q]  <= fill_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (cpu_data_ready) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Randomized bench for icache_sa against a line-residency model of the cache.
module tb_icache_sa;

   localparam int unsigned WAYS       = 2;
   localparam int unsigned SETS       = 64;
   localparam int unsigned LINE_WORDS = 16;
   localparam int unsigned OFF        = $clog2(LINE_WORDS) + 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     cpu_addr_valid;
   logic [31:0]              cpu_addr;
   logic                     flush;
   logic                     cpu_data_ready;
   logic [31:0]              cpu_data_o;
   logic                     mem_addr_valid;
   logic [31:0]              mem_addr;
   logic                     mem_data_ready;
   logic [LINE_WORDS*32-1:0] mem_data_i;
`ifdef ICACHE_STATS_EN
   logic [31:0]              hit_count, miss_count;
`endif

   icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_addr_valid (cpu_addr_valid),
      .cpu_addr       (cpu_addr),
      .flush          (flush),
      .cpu_data_ready (cpu_data_ready),
      .cpu_data_o     (cpu_data_o),
      .mem_addr_valid (mem_addr_valid),
      .mem_addr       (mem_addr),
      .mem_data_ready (mem_data_ready),
      .mem_data_i     (mem_data_i)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   // Model: which line address each way of each set holds.
   bit          m_valid [SETS][WAYS];
   logic [31:0] m_line  [SETS][WAYS];
   int unsigned m_rr    [SETS];
   int unsigned m_hits, m_misses;

   function automatic int unsigned set_of(logic [31:0] a);
      return (a >> OFF) % SETS;
   endfunction

   function automatic logic [31:0] line_of(logic [31:0] a);
      return (a >> OFF) << OFF;
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] ln, int unsigned w);
      if (ln == 32'h0000_1000 && w == 1) return 32'hDEAD_BEEF;
      return (ln * 32'd2654435761) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A00_00A5;
   endfunction

   function automatic logic [LINE_WORDS*32-1:0] line_data(logic [31:0] ln);
      logic [LINE_WORDS*32-1:0] d;
      for (int w = 0; w < int'(LINE_WORDS); w++) d[w*32 +: 32] = mem_word(ln, w);
      return d;
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      for (int w = 0; w < int'(WAYS); w++)
         if (m_valid[set_of(a)][w] && m_line[set_of(a)][w] == line_of(a)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void m_install(logic [31:0] ln);
      int s, v;
      s = set_of(ln);
      v = -1;
      for (int w = 0; w < int'(WAYS); w++) if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) v = int'(m_rr[s]);
      m_line[s][v]  = ln;
      m_valid[s][v] = 1'b1;
      m_rr[s]       = (m_rr[s] + 1) % WAYS;
   endfunction

   function automatic void m_flush();
      for (int s = 0; s < int'(SETS); s++)
         for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
   endfunction

   function automatic void m_reset();
      m_flush();
      for (int s = 0; s < int'(SETS); s++) m_rr[s] = 0;
      m_hits   = 0;
      m_misses = 0;
   endfunction

   // Entered right after the miss cycle; runs the refill and updates the model.
   task automatic refill(input logic [31:0] ln, input bit fl, input bit wander);
      int unsigned lat;
      bit discard;
      lat     = $urandom_range(0, 2);
      discard = 1'b0;
      m_misses++;
      for (int i = 0; i <= int'(lat); i++) begin
         @(negedge clk);
         mem_data_ready = 1'b0;
         flush          = fl && (i == 0);
         if (wander) begin
            cpu_addr       = $urandom;
            cpu_addr_valid = 1'($urandom_range(0, 1));
         end
         #1;
         check("refill_valid", {31'b0, mem_addr_valid}, 32'd1);
         check("refill_addr", mem_addr, ln);
         check("refill_no_hit", {31'b0, cpu_data_ready}, 32'd0);
         if (flush) begin
            m_flush();
            discard = 1'b1;
         end
      end
      @(negedge clk);
      flush          = 1'b0;
      mem_data_ready = 1'b1;
      mem_data_i     = line_data(ln);
      #1;
      check("refill_addr_hold", mem_addr, ln);
      if (!discard) m_install(ln);
   endtask

   // Presents a fetch until it hits; first_hit captures the DUT's first answer.
   task automatic fetch(input logic [31:0] a, input bit fl_mid, input bit wander,
                        output bit first_hit);
      bit h, first;
      first = 1'b1;
      do begin
         @(negedge clk);
         cpu_addr_valid = 1'b1;
         cpu_addr       = a;
         flush          = 1'b0;
         mem_data_ready = ($urandom_range(0, 3) == 0);
         mem_data_i     = {LINE_WORDS{$urandom}};
         #1;
         h = m_hit(a);
         if (first) first_hit = cpu_data_ready;
         check("hit", {31'b0, cpu_data_ready}, {31'b0, h});
         check("idle_mem_valid", {31'b0, mem_addr_valid}, 32'd0);
         check("idle_mem_addr", mem_addr, 32'd0);
         if (h) begin
            check("data", cpu_data_o, mem_word(line_of(a), (a >> 2) % LINE_WORDS));
            m_hits++;
         end else begin
            refill(line_of(a), first & fl_mid, wander);
         end
         first = 1'b0;
      end while (!h);
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush          = 1'b1;
      cpu_addr_valid = 1'b1;
      cpu_addr       = 32'h0000_1004;
      mem_data_ready = 1'b0;
      #1;
      check("flush_no_hit", {31'b0, cpu_data_ready}, 32'd0);
      m_flush();
      @(negedge clk);
      flush          = 1'b0;
      cpu_addr_valid = 1'b0;
      #1;
      check("flush_no_miss", {31'b0, mem_addr_valid}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      cpu_addr_valid = 1'b1;
      #1;
      check("rst_mem_valid", {31'b0, mem_addr_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_ready", {31'b0, cpu_data_ready}, 32'd0);
      m_reset();
      @(negedge clk);
      rst_n          = 1'b1;
      cpu_addr_valid = 1'b0;
   endtask

   initial begin
      bit fh;
      logic [31:0] a;
      int unsigned r;
      rst_n          = 1'b0;
      cpu_addr_valid = 1'b1;
      cpu_addr       = 32'h0000_1004;
      flush          = 1'b0;
      mem_data_ready = 1'b0;
      mem_data_i     = '0;
      #1;
      check("rst_mem_valid", {31'b0, mem_addr_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_ready", {31'b0, cpu_data_ready}, 32'd0);
      m_reset();
      @(negedge clk);
      rst_n          = 1'b1;
      cpu_addr_valid = 1'b0;

      // Cold miss, then three hits on the same line.
      fetch(32'h0000_1004, 1'b0, 1'b0, fh);
      check("cold_miss", {31'b0, fh}, 32'd0);
      fetch(32'h0000_1004, 1'b0, 1'b0, fh);
      fetch(32'h0000_1008, 1'b0, 1'b0, fh);
      fetch(32'h0000_1000, 1'b0, 1'b0, fh);
      @(negedge clk);
      cpu_addr_valid = 1'b0;
`ifdef ICACHE_STATS_EN
      #1;
      check("stats_hits", hit_count, 32'd4);
      check("stats_misses", miss_count, 32'd1);
`endif

      // Flush, then flush during a refill.
      do_flush();
      fetch(32'h0000_1004, 1'b0, 1'b0, fh);
      check("miss_after_flush", {31'b0, fh}, 32'd0);
      fetch(32'h0000_2044, 1'b1, 1'b1, fh);

      // Two ways per set, third line evicts the first.
      do_reset();
      fetch(32'h0000_1000, 1'b0, 1'b0, fh);
      fetch(32'h0000_2000, 1'b0, 1'b0, fh);
      fetch(32'h0000_1000, 1'b0, 1'b0, fh);
      check("assoc_hit_a", {31'b0, fh}, 32'd1);
      fetch(32'h0000_2000, 1'b0, 1'b0, fh);
      check("assoc_hit_b", {31'b0, fh}, 32'd1);
      fetch(32'h0000_3000, 1'b0, 1'b0, fh);
      fetch(32'h0000_2000, 1'b0, 1'b0, fh);
      check("keep_b", {31'b0, fh}, 32'd1);
      fetch(32'h0000_1000, 1'b0, 1'b0, fh);
      check("evict_a", {31'b0, fh}, 32'd0);

      // Reset during refill: late mem_data_ready must not install the line.
      @(negedge clk);
      cpu_addr_valid = 1'b1;
      cpu_addr       = 32'h0000_5040;
      mem_data_ready = 1'b0;
      @(negedge clk);
      #1;
      check("pre_rst_refill", {31'b0, mem_addr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'b0, mem_addr_valid}, 32'd0);
      check("rst_mid_addr", mem_addr, 32'd0);
      m_reset();
      @(negedge clk);
      rst_n          = 1'b1;
      cpu_addr_valid = 1'b0;
      @(negedge clk);
      mem_data_ready = 1'b1;
      mem_data_i     = line_data(32'h0000_5040);
      @(negedge clk);
      mem_data_ready = 1'b0;
      cpu_addr_valid = 1'b1;
      cpu_addr       = 32'h0000_5040;
      #1;
      check("late_data_ignored", {31'b0, cpu_data_ready}, 32'd0);
      refill(32'h0000_5040, 1'b0, 1'b0);
      fetch(32'h0000_5040, 1'b0, 1'b0, fh);
      check("refill_after_rst", {31'b0, fh}, 32'd1);

      // Random traffic over a few conflicting lines.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 19);
         a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 3)) << OFF) |
             (32'($urandom_range(0, LINE_WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
         if (r == 0) do_flush();
         else fetch(a, r == 1, r < 6, fh);
      end
      @(negedge clk);
      cpu_addr_valid = 1'b0;
`ifdef ICACHE_STATS_EN
      #1;
      check("stats_hits_end", hit_count, m_hits);
      check("stats_misses_end", miss_count, m_misses);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 The block SHALL take parameter WAYS, default 2, meaning the number of ways per set (power of 2, 1..8).
REQ-002 The block SHALL take parameter SETS, default 64, meaning the number of sets (power of 2, ≥2).
REQ-003 The block SHALL take parameter LINE_WORDS, default 16, meaning the number of 32-bit words per line (power of 2, ≥2).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_addr_valid, input, 1 bit, fetch request.
REQ-007 The block SHALL have port cpu_addr, input, 32 bits, byte fetch address (bits [1:0] ignored).
REQ-008 The block SHALL have port flush, input, 1 bit, invalidate all lines.
REQ-009 The block SHALL have port cpu_data_ready, output, 1 bit, hit and cpu_data_o valid this cycle.
REQ-010 The block SHALL have port cpu_data_o, output, 32 bits, fetched instruction word.
REQ-011 The block SHALL have port mem_addr_valid, output, 1 bit, line refill request.
REQ-012 The block SHALL have port mem_addr, output, 32 bits, line-aligned refill address.
REQ-013 The block SHALL have port mem_data_ready, input, 1 bit, refill line present on mem_data_i.
REQ-014 The block SHALL have port mem_data_i, input, LINE_WORDS*32 bits, refill line; word 0 in bits [31:0].

Function
REQ-015 Address split SHALL be: offset = log2(LINE_WORDS)+2 low bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-016 Hit SHALL be combinational: cpu_data_ready = cpu_addr_valid & state==IDLE & !flush & (some way valid with matching tag at index).
REQ-017 cpu_data_o SHALL be the addressed word of the hitting way; its value is don't-care when cpu_data_ready is 0.
REQ-018 The FSM SHALL have states IDLE and REFILL.
REQ-019 In IDLE, a miss (cpu_addr_valid & !hit & !flush) SHALL latch the line-aligned address and the victim way and move to REFILL next cycle.
REQ-020 In REFILL, mem_addr_valid SHALL be 1 and mem_addr SHALL be the latched address; both SHALL stay constant until mem_data_ready.
REQ-021 In IDLE, mem_addr_valid SHALL be 0 and mem_addr SHALL be 0.
REQ-022 On mem_data_ready in REFILL, the line SHALL be written to the victim way, its tag written, and valid set; the FSM SHALL return to IDLE, and the next-cycle fetch of that address SHALL hit.
REQ-023 Minimum miss penalty SHALL be 2 cycles plus memory latency: miss cycle, at least one REFILL cycle, then the hit cycle.
REQ-024 A change or drop of cpu_addr/cpu_addr_valid during REFILL SHALL NOT abort or alter the refill of the latched line.
REQ-025 The victim SHALL be an invalid way if one exists (lowest index first); otherwise it SHALL be the per-set round-robin pointer, which advances by 1 mod WAYS on each fill of that set.
REQ-026 mem_data_ready in IDLE SHALL be ignored.
REQ-027 flush SHALL clear all valid bits at the next edge.
REQ-028 If flush is asserted during REFILL, the refill SHALL continue until mem_data_ready, and the returned line SHALL be discarded (valid not set).
REQ-029 Round-robin pointers SHALL NOT be changed by flush.
REQ-030 With WAYS=1 the block SHALL behave as a direct-mapped cache.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear all valid bits, zero all round-robin pointers, force state IDLE, and drive mem_addr_valid=0, mem_addr=0, cpu_data_ready=0.
REQ-032 Reset during REFILL SHALL abandon the refill; a mem_data_ready arriving after release SHALL be ignored.
REQ-033 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-034 When macro ICACHE_STATS_EN is defined, the block SHALL add 32-bit outputs hit_count and miss_count; each resets to 0 and increments by 1 on each cycle that cpu_data_ready is 1 (hit_count) or that IDLE moves to REFILL (miss_count), wrapping at 2^32.
REQ-035 When ICACHE_STATS_EN is undefined, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Cold miss: after reset, fetch 0x0000_1004 -> mem_addr_valid=1, mem_addr=0x0000_1000 next cycle; mem_data_ready with word1=0xDEAD_BEEF -> next cycle cpu_data_ready=1, cpu_data_o=0xDEAD_BEEF.
REQ-037 Associativity: with WAYS=2, fill 0x0000_1000 then 0x0000_2000 (same index) -> both hit with no new mem request; a third line 0x0000_3000 evicts 0x0000_1000 (round-robin pointer=0).
REQ-038 Flush: after REQ-036, pulse flush -> fetch 0x0000_1004 misses and mem_addr=0x0000_1000.
REQ-039 Flush mid-refill: flush during REFILL, then mem_data_ready -> the same address misses again next cycle.
REQ-040 Reset mid-refill: drop rst_n during REFILL -> mem_addr_valid=0 immediately; a later mem_data_ready is ignored and the line is not valid.
REQ-041 Stats (ICACHE_STATS_EN): sequence of REQ-036 plus 3 hits -> miss_count=1, hit_count=4.
